aq_sysio_lpmd_seq: RTL and testbench
====================================

# aq_sysio_lpmd_seq

- Sits downstream of the CP0 low-power FSM, which drives `cp0_biu_lpmd_b`.
- Sequences core entry into and exit from WFI sleep at the system-I/O boundary:
  - blocks new bus issue;
  - drains outstanding BIU transactions;
  - runs a 4-phase request/acknowledge handshake with the external PMU;
  - gates the bus-side clock enable;
  - enforces a wake-up settle delay before releasing the core.

## Interface

Parameters:
- `OSTD_W`, default 4: width of the outstanding-transaction counter. Maximum count is 2^OSTD_W-1.
- `WAKE_DLY`, default 8: cycles spent in EXIT after PMU ack falls. Legal range 1..255.

Ports:
- `forever_cpuclk` in 1: single free-running clock.
- `cpurst` in 1: reset, asynchronous, active-high.
- `cp0_biu_lpmd_b` in 2: 2'b00 requests WFI sleep; 2'b11 means run/wake. Other codes are treated as 2'b11.
- `biu_req_issue` in 1: one bus request accepted this cycle.
- `biu_resp_done` in 1: one bus response completed this cycle.
- `pmu_lpmd_ack` in 1: PMU acknowledge; level signal, 4-phase handshake.
- `sysio_pmu_lpmd_req` out 1: sleep request to PMU.
- `sysio_pmu_lpmd_b` out 2: registered low-power code to the SoC. 2'b00 only while in SLEEP.
- `sysio_biu_block` out 1: BIU must not issue new requests.
- `sysio_clk_en` out 1: bus-side clock enable.
- `sysio_ostd_err` out 1: sticky counter or protocol error.
- `sysio_lpmd_state` out 3: current FSM state.

## Operation

State encoding: RUN=3'b000, DRAIN=3'b001, REQ=3'b010, SLEEP=3'b011, EXIT=3'b100. Any other encoding goes to RUN.

Transitions:
- RUN -> DRAIN when `cp0_biu_lpmd_b`==00.
- DRAIN:
  - -> RUN if `cp0_biu_lpmd_b`==11 (abort); abort takes priority;
  - else -> REQ when `ostd`==0 and `biu_req_issue`==0 and `biu_resp_done`==0 this cycle.
- REQ:
  - -> EXIT if `cp0_biu_lpmd_b`==11 (abort);
  - else -> SLEEP when `pmu_lpmd_ack`==1.
- SLEEP -> EXIT when `cp0_biu_lpmd_b`==11.
- EXIT:
  - on entry, load `wake_cnt`=WAKE_DLY;
  - while `pmu_lpmd_ack`==1, hold `wake_cnt`;
  - once ack is 0, decrement `wake_cnt` each cycle;
  - -> RUN on the cycle `wake_cnt` reaches 0.

Outputs by state (decoded from current state; `sysio_pmu_lpmd_b` is registered):
- `sysio_biu_block` = 1 in every state except RUN.
- `sysio_pmu_lpmd_req` = 1 in REQ and SLEEP only.
- `sysio_clk_en` = 0 in SLEEP and EXIT, 1 otherwise.
- `sysio_pmu_lpmd_b` <= 00 when next state is SLEEP; else <= 11.

Outstanding counter `ostd` (OSTD_W bits):
- issue only: +1; response only: -1; both in the same cycle: unchanged.
- Issue only at max: saturate and set `sysio_ostd_err`.
- Response only at 0: hold at 0 and set `sysio_ostd_err`.

Protocol errors (set `sysio_ostd_err`):
- `biu_req_issue`==1 while `sysio_biu_block`==1.
- `pmu_lpmd_ack` rising while `sysio_pmu_lpmd_req`==0.

`sysio_ostd_err` is cleared only by `cpurst`.

## Timing

- Reset (async assert, applies immediately):
  - state=RUN, `ostd`=0, `wake_cnt`=0;
  - `sysio_pmu_lpmd_req`=0, `sysio_pmu_lpmd_b`=11, `sysio_biu_block`=0, `sysio_clk_en`=1, `sysio_ostd_err`=0, `sysio_lpmd_state`=000.
- All state and counters update on the rising edge of `forever_cpuclk`.
- `cp0_biu_lpmd_b` is sampled each cycle; there is no input synchronizer (same clock).
- Issue in the RUN cycle where 00 is first seen is legal and counted. Block asserts the next cycle.
- Minimum latencies:
  - sleep entry: 00 seen -> DRAIN +1 -> REQ +2 (with `ostd`==0) -> SLEEP one cycle after ack is sampled high.
  - `sysio_pmu_lpmd_b`=00 in the same cycle SLEEP is entered.
  - wake: 11 seen in SLEEP -> EXIT +1, req drops the same cycle; with ack already low, RUN after WAKE_DLY further cycles, `sysio_clk_en`=1 in the RUN cycle.
- PMU handshake:
  - req holds until ack rises or an abort occurs;
  - the next req is not raised until ack has returned to 0, which EXIT guarantees.
- Abort in REQ with ack rising in the same cycle: abort wins, go to EXIT, wait for ack to fall.
- Reset mid-sleep: all outputs return to reset values immediately. The PMU must tolerate req dropping without ack.

## Test plan

1. **Basic sleep/wake.** Reset, then `cp0_biu_lpmd_b`=00 with `ostd`=0; ack 1 cycle after req; release 11 after 20 cycles. Required:
   - state sequence 000 -> 001 -> 010 -> 011 -> 100 -> 000;
   - `sysio_clk_en` low for exactly (SLEEP cycles + 8);
   - `sysio_pmu_lpmd_b`=00 only in SLEEP.
2. **Drain.** 3 issues in RUN, then 00; deliver responses at +5, +9 and +12 cycles. Required: state stays DRAIN until the cycle after the 3rd response, then REQ; `sysio_biu_block`=1 throughout.
3. **Abort in DRAIN.** 00 then 11 after 2 cycles, with `ostd`=2. Required: return to RUN; req never asserted; `sysio_clk_en` stays 1.
4. **Counter limits.** 15 issues (OSTD_W=4), then a 16th issue. Required: `ostd` stays 15 and `sysio_ostd_err`=1. After reset, a response at `ostd`=0 gives `ostd`=0 and err=1. Simultaneous issue and response at `ostd`=5 leaves `ostd`=5.
5. **Slow ack release.** Wake while ack stays high 6 more cycles. Required: EXIT holds `wake_cnt`=8 for 6 cycles, then 8 countdown cycles, then RUN.
6. **Async reset in SLEEP.** Assert `cpurst` mid-SLEEP. Required: same-cycle req=0, lpmd_b=11, clk_en=1, state=000, err=0.

Source files
------------

// File: rtl/aq_sysio_lpmd_seq.sv
// Sequences WFI sleep entry/exit at the system-I/O boundary: blocks and drains the BIU,
// handshakes with the PMU, gates the bus clock enable and enforces a wake-up settle delay.
module aq_sysio_lpmd_seq #(
  parameter int unsigned OSTD_W   = 4,
  parameter int unsigned WAKE_DLY = 8
) (
  input  logic       forever_cpuclk,
  input  logic       cpurst,
  input  logic [1:0] cp0_biu_lpmd_b,
  input  logic       biu_req_issue,
  input  logic       biu_resp_done,
  input  logic       pmu_lpmd_ack,
  output logic       sysio_pmu_lpmd_req,
  output logic [1:0] sysio_pmu_lpmd_b,
  output logic       sysio_biu_block,
  output logic       sysio_clk_en,
  output logic       sysio_ostd_err,
  output logic [2:0] sysio_lpmd_state
);

  typedef enum logic [2:0] {
    StRun   = 3'b000,
    StDrain = 3'b001,
    StReq   = 3'b010,
    StSleep = 3'b011,
    StExit  = 3'b100
  } state_e;

  localparam logic [OSTD_W-1:0] OstdMax  = {OSTD_W{1'b1}};
  localparam logic [7:0]        WakeInit = 8'(WAKE_DLY);

  state_e              r_state, w_state_nxt;
  logic [OSTD_W-1:0]   r_ostd, w_ostd_nxt;
  logic [7:0]          r_wake_cnt, w_wake_nxt;
  logic [1:0]          r_lpmd_b;
  logic                r_ack, r_err, w_err_nxt;
  logic                w_go, w_ovf, w_unf;

  // Only 2'b00 requests sleep; every other code means run.
  assign w_go = (cp0_biu_lpmd_b == 2'b00);

  always_ff @(posedge forever_cpuclk or posedge cpurst) begin
    if (cpurst) begin
      r_state    <= StRun;
      r_ostd     <= '0;
      r_wake_cnt <= '0;
      r_lpmd_b   <= 2'b11;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_ostd     <= w_ostd_nxt;
      r_wake_cnt <= w_wake_nxt;
      r_lpmd_b   <= (w_state_nxt == StSleep) ? 2'b00 : 2'b11;
      r_ack      <= pmu_lpmd_ack;
      r_err      <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StRun:   if (w_go) w_state_nxt = StDrain;
      StDrain: begin
        if (!w_go) begin
          w_state_nxt = StRun;
        end else if ((r_ostd == '0) && !biu_req_issue && !biu_resp_done) begin
          w_state_nxt = StReq;
        end
      end
      StReq: begin
        if (!w_go) begin
          w_state_nxt = StExit;
        end else if (pmu_lpmd_ack) begin
          w_state_nxt = StSleep;
        end
      end
      StSleep: if (!w_go) w_state_nxt = StExit;
      StExit:  if (!pmu_lpmd_ack && (r_wake_cnt <= 8'd1)) w_state_nxt = StRun;
      default: w_state_nxt = StRun;
    endcase
  end

  always_comb begin
    w_wake_nxt = r_wake_cnt;
    if ((w_state_nxt == StExit) && (r_state != StExit)) begin
      w_wake_nxt = WakeInit;
    end else if ((r_state == StExit) && !pmu_lpmd_ack && (r_wake_cnt != 8'd0)) begin
      w_wake_nxt = r_wake_cnt - 8'd1;
    end
  end

  always_comb begin
    w_ostd_nxt = r_ostd;
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    if (biu_req_issue && !biu_resp_done) begin
      if (r_ostd == OstdMax) w_ovf = 1'b1;
      else                   w_ostd_nxt = r_ostd + 1'b1;
    end else if (biu_resp_done && !biu_req_issue) begin
      if (r_ostd == '0) w_unf = 1'b1;
      else              w_ostd_nxt = r_ostd - 1'b1;
    end
  end

  // Sticky: counter misuse, issue while blocked, or an unsolicited ack rising edge.
  always_comb begin
    w_err_nxt = r_err | w_ovf | w_unf
              | (biu_req_issue & sysio_biu_block)
              | (pmu_lpmd_ack & ~r_ack & ~sysio_pmu_lpmd_req);
  end

  always_comb begin
    sysio_biu_block    = (r_state != StRun);
    sysio_pmu_lpmd_req = (r_state == StReq) || (r_state == StSleep);
    sysio_clk_en       = !((r_state == StSleep) || (r_state == StExit));
  end

  assign sysio_pmu_lpmd_b = r_lpmd_b;
  assign sysio_ostd_err   = r_err;
  assign sysio_lpmd_state = r_state;

endmodule

// File: tb/tb_aq_sysio_lpmd_seq.sv
// Directed plus randomized bench for aq_sysio_lpmd_seq against a behavioural sleep-sequencer model.
module tb_aq_sysio_lpmd_seq;

  localparam int OSTD_W = 4;
  localparam int WAKE   = 8;
  localparam int OMAX   = (1 << OSTD_W) - 1;
  localparam int MRun = 0, MDrain = 1, MReq = 2, MSleep = 3, MExit = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lpmd = 2'b11;
  logic       issue = 1'b0, resp = 1'b0, ack = 1'b0;
  logic       req, block, clk_en, err;
  logic [1:0] lpmd_b;
  logic [2:0] st;

  int n_vec = 0, n_err = 0, n_clk_low = 0;
  int m_st, m_ostd, m_wake;
  bit m_err, m_ack_prev;

  aq_sysio_lpmd_seq #(.OSTD_W(OSTD_W), .WAKE_DLY(WAKE)) dut (
    .forever_cpuclk     (clk),
    .cpurst             (rst),
    .cp0_biu_lpmd_b     (lpmd),
    .biu_req_issue      (issue),
    .biu_resp_done      (resp),
    .pmu_lpmd_ack       (ack),
    .sysio_pmu_lpmd_req (req),
    .sysio_pmu_lpmd_b   (lpmd_b),
    .sysio_biu_block    (block),
    .sysio_clk_en       (clk_en),
    .sysio_ostd_err     (err),
    .sysio_lpmd_state   (st)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] st_code(input int s);
    case (s)
      MDrain:  return 3'b001;
      MReq:    return 3'b010;
      MSleep:  return 3'b011;
      MExit:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic model_reset();
    m_st = MRun; m_ostd = 0; m_wake = 0; m_err = 0; m_ack_prev = 0;
  endtask

  // One clock of the reference model, using the inputs the DUT just sampled.
  task automatic model_clk();
    bit go, requesting, drained;
    go         = (lpmd == 2'b00);
    requesting = (m_st == MReq) || (m_st == MSleep);
    drained    = (m_ostd == 0) && !issue && !resp;
    if (issue && m_st != MRun) m_err = 1;
    if (ack && !m_ack_prev && !requesting) m_err = 1;
    m_ack_prev = ack;
    if (issue && !resp) begin
      if (m_ostd == OMAX) m_err = 1; else m_ostd++;
    end else if (resp && !issue) begin
      if (m_ostd == 0) m_err = 1; else m_ostd--;
    end
    case (m_st)
      MRun:   if (go) m_st = MDrain;
      MDrain: if (!go) m_st = MRun; else if (drained) m_st = MReq;
      MReq:   if (!go) begin m_st = MExit; m_wake = WAKE; end else if (ack) m_st = MSleep;
      MSleep: if (!go) begin m_st = MExit; m_wake = WAKE; end
      default: if (!ack) begin
        m_wake--;
        if (m_wake == 0) m_st = MRun;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 8'(st), 8'(st_code(m_st)));
    chk({tag, ".req"},   8'(req), 8'((m_st == MReq) || (m_st == MSleep)));
    chk({tag, ".lpmdb"}, 8'(lpmd_b), (m_st == MSleep) ? 8'h0 : 8'h3);
    chk({tag, ".block"}, 8'(block), 8'(m_st != MRun));
    chk({tag, ".clken"}, 8'(clk_en), 8'(!((m_st == MSleep) || (m_st == MExit))));
    chk({tag, ".err"},   8'(err), 8'(m_err));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_clk();
    #1;
    if (clk_en === 1'b0) n_clk_low++;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; lpmd = 2'b11; issue = 0; resp = 0; ack = 0;
    #1;
    model_reset();
    check_all("rst");
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    model_reset();

    // 1: basic sleep/wake, 20 SLEEP cycles then 8 EXIT cycles
    do_reset();
    n_clk_low = 0;
    lpmd = 2'b00;
    step("t1.drain");
    step("t1.req");
    step("t1.req2");
    ack = 1'b1;
    step("t1.sleep");
    for (int i = 0; i < 19; i++) step("t1.sleep_hold");
    lpmd = 2'b11; ack = 1'b0;
    for (int i = 0; i < 8; i++) step("t1.exit");
    step("t1.run");
    chk("t1.clk_low", 8'(n_clk_low), 8'(20 + WAKE));
    chk("t1.final_state", 8'(st), 8'h0);

    // 2: drain with three outstanding, responses at +5/+9/+12
    do_reset();
    issue = 1'b1;
    for (int i = 0; i < 3; i++) step("t2.issue");
    issue = 1'b0; lpmd = 2'b00;
    step("t2.drain");
    for (int i = 1; i <= 13; i++) begin
      resp = (i == 5) || (i == 9) || (i == 12);
      step("t2.wait");
      chk("t2.state_dir", 8'(st), (i < 13) ? 8'h1 : 8'h2);
    end
    resp = 1'b0; lpmd = 2'b11;
    for (int i = 0; i < WAKE; i++) step("t2.exit");

    // 3: abort in DRAIN with two outstanding
    do_reset();
    issue = 1'b1;
    step("t3.issue"); step("t3.issue");
    issue = 1'b0; lpmd = 2'b00;
    step("t3.drain"); step("t3.drain2");
    lpmd = 2'b11;
    step("t3.abort");
    chk("t3.state_dir", 8'(st), 8'h0);
    resp = 1'b1;
    step("t3.resp"); step("t3.resp");
    resp = 1'b0;

    // 4: counter limits
    do_reset();
    issue = 1'b1;
    for (int i = 0; i < OMAX; i++) step("t4.fill");
    chk("t4.ostd_full", 8'(dut.r_ostd), 8'(OMAX));
    step("t4.ovf");
    chk("t4.ostd_sat", 8'(dut.r_ostd), 8'(OMAX));
    chk("t4.err_ovf", 8'(err), 8'h1);
    do_reset();
    issue = 1'b0; resp = 1'b1;
    step("t4.unf");
    chk("t4.ostd_unf", 8'(dut.r_ostd), 8'h0);
    chk("t4.err_unf", 8'(err), 8'h1);
    do_reset();
    resp = 1'b0; issue = 1'b1;
    for (int i = 0; i < 5; i++) step("t4.five");
    resp = 1'b1;
    step("t4.both");
    chk("t4.ostd_both", 8'(dut.r_ostd), 8'h5);
    issue = 1'b0; resp = 1'b0;

    // 5: slow ack release on wake
    do_reset();
    lpmd = 2'b00;
    step("t5.drain"); step("t5.req");
    ack = 1'b1;
    step("t5.sleep"); step("t5.sleep2");
    lpmd = 2'b11;
    step("t5.exit");
    for (int i = 0; i < 6; i++) begin
      step("t5.hold");
      chk("t5.wake_hold", dut.r_wake_cnt, 8'(WAKE));
    end
    ack = 1'b0;
    for (int j = 1; j <= WAKE; j++) begin
      step("t5.count");
      chk("t5.wake_cnt", dut.r_wake_cnt, 8'(WAKE - j));
    end

    // 6: async reset mid-SLEEP, outputs must react without a clock edge
    do_reset();
    lpmd = 2'b00;
    step("t6.drain"); step("t6.req");
    ack = 1'b1;
    step("t6.sleep"); step("t6.sleep2");
    #2 rst = 1'b1;
    #1;
    chk("t6.req", 8'(req), 8'h0);
    chk("t6.lpmdb", 8'(lpmd_b), 8'h3);
    chk("t6.clken", 8'(clk_en), 8'h1);
    chk("t6.state", 8'(st), 8'h0);
    chk("t6.err", 8'(err), 8'h0);
    model_reset();
    @(negedge clk);
    ack = 1'b0; lpmd = 2'b11; rst = 1'b0;

    // Randomized episodes; the last one is unconstrained to exercise the error paths.
    for (int ep = 0; ep < 4; ep++) begin
      do_reset();
      for (int c = 0; c < 250; c++) begin
        if ($urandom_range(11) == 0) begin
          if (lpmd == 2'b00) lpmd = 2'($urandom_range(3, 1));
          else               lpmd = 2'b00;
        end
        if (ep == 3) begin
          issue = 1'($urandom);
          resp  = 1'($urandom);
          ack   = 1'($urandom);
        end else begin
          issue = (m_st == MRun) && ($urandom_range(2) == 0);
          resp  = (m_ostd > 0) && ($urandom_range(2) == 0);
          if ((m_st == MReq) || (m_st == MSleep)) begin
            if ($urandom_range(2) == 0) ack = 1'b1;
          end else if ($urandom_range(1) == 0) begin
            ack = 1'b0;
          end
        end
        step("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
